// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and control-flow controller for the in-order pipeline.
// A scoreboard of in-flight destinations behind decode drives stalls, bypass selects and PC redirect.
module pipe_hazard_ctrl #(
  parameter int REG_W         = 3,
  parameter int DEPTH         = 3,
  parameter int RESOLVE_STAGE = 1,
  parameter int FORWARDING    = 1,
  parameter int BRANCH_MODE   = 0,
  parameter int FWD_W         = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reads_rs,
  input  logic             id_reads_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             id_is_load,
  input  logic             id_borj,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pc_redirect,
  output logic [FWD_W-1:0] fwd_sel_a,
  output logic [FWD_W-1:0] fwd_sel_b,
  output logic [CNT_W-1:0] stall_cycles
);

  // Slot DEPTH (WB) never raises a hazard thanks to the write-through register
  // file, so only slots 1..DEPTH-1 are kept; only slot 1 needs the load flag.
  localparam int NS   = DEPTH - 1;
  localparam int SH_W = $clog2(DEPTH + 1);

  logic [NS:1]             valid_q, valid_d;
  logic [NS:1]             wr_q, wr_d;
  logic [NS:1][REG_W-1:0]  wreg_q, wreg_d;
  logic                    load1_q, load1_d;
  logic [SH_W-1:0]         shadow_q, shadow_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NS:1]      hit_rs, hit_rt;
  logic [FWD_W-1:0] sel_rs, sel_rt;
  logic             use_rs, use_rt;
  logic             raw_rs, raw_rt, lu_rs, lu_rt;
  logic             data_stall;
  logic             shadow_act, shadow_last;
  logic             advance, kill_young, stall_evt;

  genvar gi;

  generate
    for (gi = 1; gi <= NS; gi++) begin : g_match
      assign hit_rs[gi] = valid_q[gi] & wr_q[gi] & (wreg_q[gi] == id_rs);
      assign hit_rt[gi] = valid_q[gi] & wr_q[gi] & (wreg_q[gi] == id_rt);
    end
  endgenerate

  // Walk from the oldest tracked slot down so the youngest producer wins.
  always_comb begin
    sel_rs = '0;
    sel_rt = '0;
    for (int k = NS; k >= 1; k--) begin
      if (hit_rs[k]) sel_rs = FWD_W'(k);
      if (hit_rt[k]) sel_rt = FWD_W'(k);
    end
  end

  assign use_rs = id_valid & id_reads_rs;
  assign use_rt = id_valid & id_reads_rt;
  assign raw_rs = use_rs & (|hit_rs);
  assign raw_rt = use_rt & (|hit_rt);
  assign lu_rs  = use_rs & hit_rs[1] & load1_q;
  assign lu_rt  = use_rt & hit_rt[1] & load1_q;

  assign data_stall = (FORWARDING != 0) ? (lu_rs | lu_rt) : (raw_rs | raw_rt);

  assign shadow_act  = (shadow_q != '0);
  assign shadow_last = (shadow_q == SH_W'(1));

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_redirect  = 1'b0;
    fwd_sel_a    = (FORWARDING != 0 && use_rs) ? sel_rs : '0;
    fwd_sel_b    = (FORWARDING != 0 && use_rt) ? sel_rt : '0;
    advance      = 1'b1;
    kill_young   = 1'b0;
    stall_evt    = 1'b0;

    if (rst) begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      advance   = 1'b0;
    end else if (mem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      advance   = 1'b0;
      stall_evt = 1'b1;
    end else if (BRANCH_MODE != 0 && ex_redirect) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      kill_young   = 1'b1;
      fwd_sel_a    = '0;
      fwd_sel_b    = '0;
    end else begin
      if (data_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        fwd_sel_a    = '0;
        fwd_sel_b    = '0;
        stall_evt    = 1'b1;
      end
      // While a branch is in the shadow, fetch waits; a held IF_ID is not flushed
      // and the resolve cycle still steers the PC.
      if (BRANCH_MODE == 0 && shadow_act) begin
        if_id_flush = ~data_stall;
        pc_we       = shadow_last;
        pc_redirect = shadow_last & ex_redirect;
      end
    end
  end

  assign valid_d[1] = advance ? (id_valid & ~id_ex_bubble) : valid_q[1];
  assign wr_d[1]    = advance ? id_writes : wr_q[1];
  assign wreg_d[1]  = advance ? id_wreg : wreg_q[1];
  assign load1_d    = advance ? id_is_load : load1_q;

  generate
    for (gi = 2; gi <= NS; gi++) begin : g_shift
      localparam bit YOUNGER = (gi - 1 < RESOLVE_STAGE);
      assign valid_d[gi] = advance ? (valid_q[gi-1] & ~(kill_young & YOUNGER)) : valid_q[gi];
      assign wr_d[gi]    = advance ? wr_q[gi-1] : wr_q[gi];
      assign wreg_d[gi]  = advance ? wreg_q[gi-1] : wreg_q[gi];
    end
  endgenerate

  always_comb begin
    shadow_d = shadow_q;
    if (advance) begin
      if (BRANCH_MODE == 0 && id_valid && id_borj && !id_ex_bubble)
        shadow_d = SH_W'(RESOLVE_STAGE);
      else if (shadow_act)
        shadow_d = shadow_q - SH_W'(1);
    end
  end

  assign cnt_d = (stall_evt && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_q     <= '0;
      wreg_q   <= '0;
      load1_q  <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_q     <= wr_d;
      wreg_q   <= wreg_d;
      load1_q  <= load1_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance A forwards with predict-not-taken, instance B stalls on
// every RAW with branch shadowing and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic       reads_rs;
    logic [2:0] rt;
    logic       reads_rt;
    logic       writes;
    logic [2:0] wreg;
    logic       is_load;
    logic       borj;
    logic       redirect;
    logic       mem_stall;
  } stim_t;

  logic  clk;
  logic  rst_a, rst_b;
  stim_t sa, sb;
  int    total = 0;
  int    bad = 0;

  logic        a_pc_we, a_if_id_we, a_flush, a_bubble, a_redir;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_cnt;
  logic        b_pc_we, b_if_id_we, b_flush, b_bubble, b_redir;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [3:0]  b_cnt;

  pipe_hazard_ctrl #(
    .REG_W(3), .DEPTH(3), .RESOLVE_STAGE(1), .FORWARDING(1),
    .BRANCH_MODE(1), .FWD_W(2), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst_a), .id_valid(sa.valid), .id_rs(sa.rs), .id_rt(sa.rt),
    .id_reads_rs(sa.reads_rs), .id_reads_rt(sa.reads_rt), .id_writes(sa.writes),
    .id_wreg(sa.wreg), .id_is_load(sa.is_load), .id_borj(sa.borj),
    .ex_redirect(sa.redirect), .mem_stall(sa.mem_stall),
    .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_flush),
    .id_ex_bubble(a_bubble), .pc_redirect(a_redir),
    .fwd_sel_a(a_fwd_a), .fwd_sel_b(a_fwd_b), .stall_cycles(a_cnt)
  );

  pipe_hazard_ctrl #(
    .REG_W(3), .DEPTH(3), .RESOLVE_STAGE(1), .FORWARDING(0),
    .BRANCH_MODE(0), .FWD_W(2), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst_b), .id_valid(sb.valid), .id_rs(sb.rs), .id_rt(sb.rt),
    .id_reads_rs(sb.reads_rs), .id_reads_rt(sb.reads_rt), .id_writes(sb.writes),
    .id_wreg(sb.wreg), .id_is_load(sb.is_load), .id_borj(sb.borj),
    .ex_redirect(sb.redirect), .mem_stall(sb.mem_stall),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_flush),
    .id_ex_bubble(b_bubble), .pc_redirect(b_redir),
    .fwd_sel_a(b_fwd_a), .fwd_sel_b(b_fwd_b), .stall_cycles(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(input int v, input int rs, input int rrs, input int rt,
                               input int rrt, input int w, input int wd, input int ld,
                               input int bj);
    stim_t s;
    s          = '0;
    s.valid    = 1'(v);
    s.rs       = 3'(rs);
    s.reads_rs = 1'(rrs);
    s.rt       = 3'(rt);
    s.reads_rt = 1'(rrt);
    s.writes   = 1'(w);
    s.wreg     = 3'(wd);
    s.is_load  = 1'(ld);
    s.borj     = 1'(bj);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int pc, input int ifid, input int fl,
                       input int bb, input int rd);
    chk({tag, ".pc_we"}, 32'(a_pc_we), pc);
    chk({tag, ".if_id_we"}, 32'(a_if_id_we), ifid);
    chk({tag, ".flush"}, 32'(a_flush), fl);
    chk({tag, ".bubble"}, 32'(a_bubble), bb);
    chk({tag, ".redirect"}, 32'(a_redir), rd);
  endtask

  task automatic chk_b(input string tag, input int pc, input int ifid, input int fl,
                       input int bb, input int rd);
    chk({tag, ".pc_we"}, 32'(b_pc_we), pc);
    chk({tag, ".if_id_we"}, 32'(b_if_id_we), ifid);
    chk({tag, ".flush"}, 32'(b_flush), fl);
    chk({tag, ".bubble"}, 32'(b_bubble), bb);
    chk({tag, ".redirect"}, 32'(b_redir), rd);
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    $display("step %s done at t=%0t", name, $time);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sa    = '0;
    sb    = '0;
    repeat (2) @(posedge clk);
    #1;
    sa = mk(1, 3, 1, 3, 1, 1, 3, 0, 0);
    #3;
    chk_a("a_reset", 1, 1, 0, 0, 0);
    chk("a_reset.fwd_a", 32'(a_fwd_a), 0);
    chk("a_reset.cnt", 32'(a_cnt), 0);
    chk_b("b_reset", 1, 1, 0, 0, 0);
    chk("b_reset.cnt", 32'(b_cnt), 0);
    tick("reset");

    // Load-use with forwarding: one bubble, then bypass from slot 2.
    rst_a = 1'b0;
    sa = mk(1, 0, 0, 0, 0, 1, 3, 1, 0);
    #3; chk("a1.pc_we", 32'(a_pc_we), 1);
    tick("A1 load r3");
    sa = mk(1, 3, 1, 4, 1, 1, 6, 0, 0);
    #3; chk_a("a2_loaduse", 0, 0, 0, 1, 0);
    chk("a2.fwd_a", 32'(a_fwd_a), 0);
    chk("a2.cnt", 32'(a_cnt), 0);
    tick("A2 add r6,r3,r4 stalled");
    #3; chk_a("a3_issue", 1, 1, 0, 0, 0);
    chk("a3.fwd_a", 32'(a_fwd_a), 2);
    chk("a3.fwd_b", 32'(a_fwd_b), 0);
    chk("a3.cnt", 32'(a_cnt), 1);
    tick("A3 add issues");

    // ALU producer then back-to-back Rt reads walk the bypass 1 -> 2 -> RF.
    sa = mk(1, 6, 1, 0, 0, 1, 2, 0, 0);
    #3; chk("a4.fwd_a", 32'(a_fwd_a), 1);
    chk("a4.pc_we", 32'(a_pc_we), 1);
    tick("A4 alu r2,r6");
    sa = mk(1, 0, 0, 2, 1, 0, 0, 0, 0);
    #3; chk("a5.fwd_b", 32'(a_fwd_b), 1);
    chk("a5.fwd_a", 32'(a_fwd_a), 0);
    chk("a5.bubble", 32'(a_bubble), 0);
    tick("A5 read r2");
    #3; chk("a6.fwd_b", 32'(a_fwd_b), 2);
    chk("a6.cnt", 32'(a_cnt), 1);
    tick("A6 read r2");
    #3; chk("a7.fwd_b_wb", 32'(a_fwd_b), 0);
    tick("A7 read r2");

    // Memory freeze over a pending load-use hazard.
    sa = mk(1, 0, 0, 0, 0, 1, 5, 1, 0);
    #3; chk("a8.pc_we", 32'(a_pc_we), 1);
    tick("A8 load r5");
    sa = mk(1, 5, 1, 0, 0, 1, 7, 0, 0);
    sa.mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3; chk_a($sformatf("a9_freeze%0d", i), 0, 0, 0, 0, 0);
      tick("A9 mem_stall");
    end
    sa.mem_stall = 1'b0;
    #3; chk_a("a10_loaduse", 0, 0, 0, 1, 0);
    chk("a10.cnt", 32'(a_cnt), 5);
    tick("A10 load-use after freeze");
    #3; chk("a11.fwd_a", 32'(a_fwd_a), 2);
    chk("a11.pc_we", 32'(a_pc_we), 1);
    chk("a11.cnt", 32'(a_cnt), 6);
    tick("A11 issue");

    // Predict-not-taken redirect squashes the younger instruction.
    sa = mk(1, 1, 1, 0, 0, 0, 0, 0, 1);
    #3; chk_a("a12_branch", 1, 1, 0, 0, 0);
    tick("A12 branch");
    sa = mk(1, 0, 0, 0, 0, 1, 4, 1, 0);
    sa.redirect = 1'b1;
    #3; chk_a("a13_redirect", 1, 1, 1, 1, 1);
    tick("A13 redirect");
    sa = mk(1, 4, 1, 0, 0, 0, 0, 0, 0);
    #3; chk_a("a14_no_young", 1, 1, 0, 0, 0);
    chk("a14.fwd_a", 32'(a_fwd_a), 0);
    tick("A14 read r4");
    sa = mk(1, 0, 0, 0, 0, 1, 2, 1, 0);
    #3; tick("A15 load r2");
    sa = mk(1, 2, 1, 0, 0, 0, 0, 0, 0);
    sa.redirect = 1'b1;
    #3; chk_a("a16_redir_wins", 1, 1, 1, 1, 1);
    chk("a16.cnt", 32'(a_cnt), 6);
    tick("A16 redirect over load-use");
    sa = '0;
    #3; chk("a16.cnt_after", 32'(a_cnt), 6);

    // No forwarding: DEPTH=3 producer costs two stall cycles.
    rst_b = 1'b0;
    sb = mk(1, 0, 0, 0, 0, 1, 5, 0, 0);
    #3; chk("b1.pc_we", 32'(b_pc_we), 1);
    tick("B1 alu r5");
    sb = mk(1, 5, 1, 0, 0, 1, 6, 0, 0);
    #3; chk_b("b2_raw1", 0, 0, 0, 1, 0);
    chk("b2.fwd_a", 32'(b_fwd_a), 0);
    tick("B2 read r5 stalled");
    #3; chk_b("b3_raw2", 0, 0, 0, 1, 0);
    chk("b3.cnt", 32'(b_cnt), 1);
    tick("B3 read r5 stalled");
    #3; chk_b("b4_issue", 1, 1, 0, 0, 0);
    chk("b4.fwd_a", 32'(b_fwd_a), 0);
    chk("b4.cnt", 32'(b_cnt), 2);
    tick("B4 read r5 issues");

    // Branch shadow, then async reset on the resolve cycle.
    sb = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #3; chk_b("b5_branch", 1, 1, 0, 0, 0);
    tick("B5 branch");
    sb = '0;
    sb.redirect = 1'b1;
    #3; chk_b("b6_resolve", 1, 1, 1, 0, 1);
    rst_b = 1'b1;
    #1; chk_b("b6_async_rst", 1, 1, 0, 0, 0);
    chk("b6.cnt", 32'(b_cnt), 0);
    #1; rst_b = 1'b0;
    sb = mk(1, 6, 1, 0, 0, 0, 0, 0, 0);
    #1; chk_b("b6_slots_clear", 1, 1, 0, 0, 0);
    tick("B6 reset in shadow");

    // Counter saturation at 4 bits.
    sb = '0;
    sb.mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick("B7 mem_stall");
    #3; chk("b7.cnt_sat", 32'(b_cnt), 15);
    chk("b7.pc_we", 32'(b_pc_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
